id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register with integrated load-use hazard detection, for the 5-stage pipeline.
- Captures decoded operands, register specifiers and control bits from ID each cycle.
- Feeds IDEXR1/IDEXR2 to the forwarding unit and operands and control to EX.
- On a load-use hazard it inserts a bubble and stalls PC and IF/ID. It also honours branch flush and an external hold, and keeps saturating stall/flush counters for debug.

Parameters:
- DATA_W, 64, width of register operands, immediate and PC.
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- flush  input  1  branch taken in EX; squash instruction entering ID/EX.
- hold  input  1  external freeze (e.g. memory busy); ID/EX keeps contents.
- IFIDR1  input  5  rs1 field of instruction currently in ID.
- IFIDR2  input  5  rs2 field of instruction currently in ID.
- IFIDRd  input  5  rd field of instruction in ID.
- IFIDPC  input  DATA_W  PC of instruction in ID.
- ReadData1, ReadData2  input  DATA_W  register file outputs.
- Imm  input  DATA_W  sign-extended immediate.
- CtrlIn  input  8  {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, ALUOp[1:0]} from control unit.
- IDEXR1, IDEXR2, IDEXRd  output  5  registered specifiers.
- IDEXPC, IDEXData1, IDEXData2, IDEXImm  output  DATA_W  registered operands.
- IDEXCtrl  output  8  registered control, same bit order as CtrlIn.
- IDEXValid  output  1  1 = real instruction, 0 = bubble/squashed.
- PCWrite  output  1  0 = PC must not advance.
- IFIDWrite  output  1  0 = IF/ID must not load.
- StallCount, FlushCount  output  CNT_W  saturating event counters.

Behaviour:
- Reset:
  - All registered outputs go to 0, including IDEXValid, the counters and the specifiers.
  - PCWrite = IFIDWrite = 1 the cycle after reset while reset is low and no hazard is present.
- Hazard detect (combinational, current ID/EX vs ID):
  - haz = IDEXValid & IDEXCtrl.MemRead & (IDEXRd != 0) & ((IDEXRd == IFIDR1) | (IDEXRd == IFIDR2)).
- PCWrite = IFIDWrite = ~(haz | hold). Flush does not deassert them; the fetch unit redirects the PC.
- Update priority per rising edge, highest first:
  1. reset: clear everything.
  2. flush: IDEXCtrl <= 0, IDEXValid <= 0; data and specifier fields are don't-care, implemented as load-from-ID. FlushCount increments. Flush overrides hold and haz.
  3. hold: all ID/EX fields retain their values; counters unchanged.
  4. haz: bubble. IDEXCtrl <= 0 and IDEXValid <= 0, specifiers IDEXR1/R2/Rd <= 0 so the forwarding unit never matches. StallCount increments.
  5. otherwise: load all fields from ID inputs, IDEXValid <= 1.
- A load-use hazard produces exactly one bubble cycle. After the bubble IDEXValid = 0, so haz deasserts and the stalled instruction loads on the next edge. Latency from ID input to IDEX outputs: 1 cycle.
- Counters saturate at all-ones and do not wrap. Both can increment only on distinct cycles, per the priority above.
- Reset asserted mid-stall or mid-hold: state clears on that edge; no residual stall.
- rd = 0 loads never stall.

Test Plan:
- Reset: reset=1 for 2 cycles with nonzero inputs -> all IDEX outputs 0, IDEXValid=0, counters 0; after release, first edge loads ID inputs, IDEXValid=1.
- Normal flow: ID holds add x5,x1,x2 (ReadData1=0x10, ReadData2=0x20, CtrlIn=8'b1000_0010) -> next cycle IDEXR1=1, IDEXR2=2, IDEXRd=5, IDEXData1=0x10, IDEXCtrl=8'b1000_0010, PCWrite=1.
- Load-use stall:
  - Stimulus: ID/EX holds ld x5 (MemRead=1, Rd=5) while ID has rs1=5.
  - Response: PCWrite=IFIDWrite=0 that cycle.
  - Next edge: bubble (IDEXCtrl=0, IDEXValid=0, IDEXRd=0), StallCount=1.
  - Following edge: dependent instruction loads, PCWrite=1.
- No false stall: ld x0 followed by rs1=0, and ld x5 followed by rs1=6, rs2=7 -> PCWrite stays 1, StallCount unchanged.
- Flush vs hazard/hold:
  - Stimulus: flush=1 together with haz=1 and hold=1.
  - Response: next edge IDEXCtrl=0, IDEXValid=0, FlushCount +1, StallCount unchanged.
  - Separately, hold=1 for 3 cycles: IDEX outputs frozen, PCWrite=0.
- Saturation: CNT_W=4, force 17 load-use stalls -> StallCount reaches 15 and stays at 15.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with load-use bubble insertion,
// branch flush, external hold and saturating stall/flush debug counters.
module id_ex_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              hold,
  input  logic [4:0]        IFIDR1,
  input  logic [4:0]        IFIDR2,
  input  logic [4:0]        IFIDRd,
  input  logic [DATA_W-1:0] IFIDPC,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2,
  input  logic [DATA_W-1:0] Imm,
  input  logic [7:0]        CtrlIn,
  output logic [4:0]        IDEXR1,
  output logic [4:0]        IDEXR2,
  output logic [4:0]        IDEXRd,
  output logic [DATA_W-1:0] IDEXPC,
  output logic [DATA_W-1:0] IDEXData1,
  output logic [DATA_W-1:0] IDEXData2,
  output logic [DATA_W-1:0] IDEXImm,
  output logic [7:0]        IDEXCtrl,
  output logic              IDEXValid,
  output logic              PCWrite,
  output logic              IFIDWrite,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FlushCount
);
  logic [4:0]        r1_q, r2_q, rd_q, r1_d, r2_d, rd_d;
  logic [DATA_W-1:0] pc_q, d1_q, d2_q, imm_q, pc_d, d1_d, d2_d, imm_d;
  logic [7:0]        ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  stall_q, stall_d, flush_q, flush_d;
  logic              haz, keep, bub;
  // CtrlIn[5] is MemRead; a valid load writing the register ID reads is a load-use hazard
  assign haz  = valid_q & ctrl_q[5] & (rd_q != 5'd0) & ((rd_q == IFIDR1) | (rd_q == IFIDR2));
  assign keep = hold & ~flush;
  assign bub  = haz & ~flush & ~hold;
  assign PCWrite   = ~(haz | hold);
  assign IFIDWrite = ~(haz | hold);
  always_comb begin
    r1_d    = keep ? r1_q : bub ? 5'd0 : IFIDR1;
    r2_d    = keep ? r2_q : bub ? 5'd0 : IFIDR2;
    rd_d    = keep ? rd_q : bub ? 5'd0 : IFIDRd;
    pc_d    = keep ? pc_q  : IFIDPC;
    d1_d    = keep ? d1_q  : ReadData1;
    d2_d    = keep ? d2_q  : ReadData2;
    imm_d   = keep ? imm_q : Imm;
    ctrl_d  = keep ? ctrl_q  : (flush | haz) ? 8'd0 : CtrlIn;
    valid_d = keep ? valid_q : ~(flush | haz);
    stall_d = (bub & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
    flush_d = (flush & ~&flush_q) ? flush_q + CNT_W'(1) : flush_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r1_q    <= '0;
      r2_q    <= '0;
      rd_q    <= '0;
      pc_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      rd_q    <= rd_d;
      pc_q    <= pc_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end
  assign IDEXR1     = r1_q;
  assign IDEXR2     = r2_q;
  assign IDEXRd     = rd_q;
  assign IDEXPC     = pc_q;
  assign IDEXData1  = d1_q;
  assign IDEXData2  = d2_q;
  assign IDEXImm    = imm_q;
  assign IDEXCtrl   = ctrl_q;
  assign IDEXValid  = valid_q;
  assign StallCount = stall_q;
  assign FlushCount = flush_q;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: directed stimulus with a queue scoreboard; the driver pushes
// the hand-derived expected outputs per cycle and a monitor pops and compares them.
module tb_id_ex_stage_reg;
  localparam logic [7:0] ADD = 8'b1000_0010;
  localparam logic [7:0] LD  = 8'b1110_0100;
  typedef struct packed {
    logic        rchk;
    logic        dchk;
    logic        v;
    logic [7:0]  c;
    logic [4:0]  r1, r2, rd;
    logic [63:0] d1, d2, imm, pc;
    logic        pw;
    logic [3:0]  sc, fc;
  } exp_t;
  logic clk = 1'b0, reset, flush, hold;
  logic [4:0] IFIDR1, IFIDR2, IFIDRd, IDEXR1, IDEXR2, IDEXRd;
  logic [63:0] IFIDPC, ReadData1, ReadData2, Imm, IDEXPC, IDEXData1, IDEXData2, IDEXImm;
  logic [7:0] CtrlIn, IDEXCtrl;
  logic IDEXValid, PCWrite, IFIDWrite;
  logic [3:0] StallCount, FlushCount;
  exp_t q[$];
  int total = 0, bad = 0, stepn = 0;
  id_ex_stage_reg #(.DATA_W(64), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .hold(hold),
    .IFIDR1(IFIDR1), .IFIDR2(IFIDR2), .IFIDRd(IFIDRd), .IFIDPC(IFIDPC),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Imm(Imm), .CtrlIn(CtrlIn),
    .IDEXR1(IDEXR1), .IDEXR2(IDEXR2), .IDEXRd(IDEXRd), .IDEXPC(IDEXPC),
    .IDEXData1(IDEXData1), .IDEXData2(IDEXData2), .IDEXImm(IDEXImm),
    .IDEXCtrl(IDEXCtrl), .IDEXValid(IDEXValid), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
    .StallCount(StallCount), .FlushCount(FlushCount)
  );
  always #5 clk = ~clk;
  // Operand values are derived from a tag so expectations stay short; tag 0 is all zeros
  function automatic exp_t mk(input logic rc, dc, v, input logic [7:0] c, input int r1, r2, rd, tag,
                              input logic pw, input int sc, fc);
    exp_t e;
    e.rchk = rc; e.dchk = dc; e.v = v; e.c = c;
    e.r1 = 5'(r1); e.r2 = 5'(r2); e.rd = 5'(rd);
    e.d1 = 64'(tag) << 4; e.d2 = 64'(tag) << 5; e.imm = 64'(tag) * 3; e.pc = 64'(tag) << 8;
    e.pw = pw; e.sc = 4'(sc); e.fc = 4'(fc);
    return e;
  endfunction
  task automatic drv(input logic rs, fl, hd, input int r1, r2, rd, input logic [7:0] c, input int tag);
    reset = rs; flush = fl; hold = hd;
    IFIDR1 = 5'(r1); IFIDR2 = 5'(r2); IFIDRd = 5'(rd); CtrlIn = c;
    ReadData1 = 64'(tag) << 4; ReadData2 = 64'(tag) << 5; Imm = 64'(tag) * 3; IFIDPC = 64'(tag) << 8;
  endtask
  task automatic step(input logic rs, fl, hd, input int r1, r2, rd, input logic [7:0] c, input int tag,
                      input exp_t e);
    @(negedge clk); #1;
    drv(rs, fl, hd, r1, r2, rd, c, tag);
    q.push_back(e);
  endtask
  always @(negedge clk) begin
    #2;
    if (q.size() != 0) begin
      exp_t e;
      logic ok;
      e = q.pop_front();
      stepn++;
      ok = (IDEXValid == e.v) && (IDEXCtrl == e.c) && (PCWrite == e.pw) && (IFIDWrite == e.pw)
        && (StallCount == e.sc) && (FlushCount == e.fc)
        && (!e.rchk || (IDEXR1 == e.r1 && IDEXR2 == e.r2 && IDEXRd == e.rd))
        && (!e.dchk || (IDEXData1 == e.d1 && IDEXData2 == e.d2 && IDEXImm == e.imm && IDEXPC == e.pc));
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL step%0d: got v=%0b c=%h r=%0d/%0d/%0d d=%h/%h/%h/%h pw=%0b ifw=%0b sc=%0d fc=%0d; want v=%0b c=%h r=%0d/%0d/%0d(chk %0b) d=%h/%h/%h/%h(chk %0b) pw=%0b sc=%0d fc=%0d",
          stepn, IDEXValid, IDEXCtrl, IDEXR1, IDEXR2, IDEXRd, IDEXData1, IDEXData2, IDEXImm, IDEXPC,
          PCWrite, IFIDWrite, StallCount, FlushCount, e.v, e.c, e.r1, e.r2, e.rd, e.rchk,
          e.d1, e.d2, e.imm, e.pc, e.dchk, e.pw, e.sc, e.fc);
      end
    end
  end
  initial begin
    drv(1, 0, 0, 1, 2, 5, ADD, 1);
    step(1, 0, 0, 1, 2, 5, ADD, 1, mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step(0, 0, 0, 1, 2, 5, ADD, 1, mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    step(0, 0, 0, 3, 0, 5, LD, 2, mk(1, 1, 1, ADD, 1, 2, 5, 1, 1, 0, 0));
    step(0, 0, 0, 5, 4, 6, ADD, 3, mk(1, 1, 1, LD, 3, 0, 5, 2, 0, 0, 0));
    step(0, 0, 0, 5, 4, 6, ADD, 3, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    step(0, 0, 0, 7, 0, 0, LD, 4, mk(1, 1, 1, ADD, 5, 4, 6, 3, 1, 1, 0));
    step(0, 0, 0, 0, 0, 8, ADD, 5, mk(1, 1, 1, LD, 7, 0, 0, 4, 1, 1, 0));
    step(0, 0, 0, 1, 0, 5, LD, 6, mk(1, 1, 1, ADD, 0, 0, 8, 5, 1, 1, 0));
    step(0, 0, 0, 6, 7, 9, ADD, 7, mk(1, 1, 1, LD, 1, 0, 5, 6, 1, 1, 0));
    step(0, 0, 0, 2, 0, 5, LD, 8, mk(1, 1, 1, ADD, 6, 7, 9, 7, 1, 1, 0));
    step(0, 1, 1, 0, 5, 10, ADD, 9, mk(1, 1, 1, LD, 2, 0, 5, 8, 0, 1, 0));
    step(0, 0, 0, 11, 12, 13, ADD, 10, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 14, 15, 16, ADD, 11, mk(1, 1, 1, ADD, 11, 12, 13, 10, 0, 1, 1));
    step(0, 0, 0, 14, 15, 16, ADD, 11, mk(1, 1, 1, ADD, 11, 12, 13, 10, 1, 1, 1));
    step(0, 0, 0, 1, 2, 5, LD, 12, mk(1, 1, 1, ADD, 14, 15, 16, 11, 1, 1, 1));
    step(1, 0, 0, 5, 0, 7, ADD, 13, mk(1, 1, 1, LD, 1, 2, 5, 12, 0, 1, 1));
    step(0, 0, 0, 5, 0, 7, ADD, 13, mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 17; i++) begin
      int s, s1;
      s  = (i > 15) ? 15 : i;
      s1 = (i + 1 > 15) ? 15 : i + 1;
      step(0, 0, 0, 1, 2, 5, LD, 14, mk(1, 1, 1, ADD, 5, 0, 7, 13, 1, s, 0));
      step(0, 0, 0, 5, 0, 7, ADD, 13, mk(1, 1, 1, LD, 1, 2, 5, 14, 0, s, 0));
      step(0, 0, 0, 5, 0, 7, ADD, 13, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, s1, 0));
    end
    step(0, 0, 0, 0, 0, 0, 8'd0, 0, mk(1, 1, 1, ADD, 5, 0, 7, 13, 1, 15, 0));
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #3;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
